// File: rtl/serial_collector_pkg.sv
// Shared types and helpers for the serial collector.
//   state_t      : collector FSM states (COLLECT = gathering bits, FULL = word on offer)
//   count_width  : bit width of a counter able to hold 0..width
package serial_collector_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_collector_gates.sv
// Fixed-width reduction gates consumed downstream of the collector.
//   OR_8  : a[7:0] -> y = |a
//   AND_4 : a[3:0] -> y = &a
module OR_8 (
  input  logic [7:0] a,
  output logic       y
);
  assign y = |a;
endmodule

module AND_4 (
  input  logic [3:0] a,
  output logic       y
);
  assign y = &a;
endmodule

// File: rtl/serial_collector_sipo.sv
// sipo_core: serial-in shift register plus bit counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : shift bit_in into the register and advance the count
//   clr        : synchronous clear of register and count (has priority)
//   bit_in     : serial data bit
//   word       : register contents as they will be after shifting in bit_in,
//                so the caller can capture a completed word on the last accept
//   last       : count == WIDTH-1 (the next shift completes a word)
module sipo_core
  import serial_collector_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             last
);

  localparam int unsigned CW = count_width(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;

  always_comb begin
    word = '0;
    if (MSB_FIRST) begin
      word = {sr[WIDTH-2:0], bit_in};
    end else begin
      word = {bit_in, sr[WIDTH-1:1]};
    end
  end

  assign last = (count == CW'(WIDTH - 1));

  // The count wraps to zero on the completing shift, so a bit accepted in the
  // same cycle a full word is taken naturally starts the next word at count=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      count <= '0;
    end else if (clr) begin
      sr    <= '0;
      count <= '0;
    end else if (shift_en) begin
      sr    <= word;
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_collector.sv
// serial_collector: serial-in / parallel-out word collector.
// Accepts one bit per cycle over in_valid/in_ready, assembles WIDTH-bit words and
// offers them over out_valid/out_ready with OR/AND reduction flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready combinational)
//   in_bit              : serial data bit
//   out_valid, out_ready: output handshake (out_valid registered)
//   out_word            : assembled word, held after delivery until the next load
//   out_any, out_all    : OR / AND of out_word, meaningful while out_valid
module serial_collector
  import serial_collector_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_any,
  output logic             out_all
);

  state_t           state, state_n;
  logic             valid_n;
  logic             load;
  logic             clr;
  logic             in_accept;
  logic             out_take;
  logic [WIDTH-1:0] next_word;
  logic             last;

  assign in_accept = in_valid & in_ready;
  assign out_take  = out_valid & out_ready;

  sipo_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (in_accept),
    .clr      (clr),
    .bit_in   (in_bit),
    .word     (next_word),
    .last     (last)
  );

  // In FULL the input side is only open when the consumer drains the word in the
  // same cycle, so any accepted bit there always belongs to the following word.
  always_comb begin
    state_n  = state;
    valid_n  = out_valid;
    load     = 1'b0;
    clr      = 1'b0;
    in_ready = 1'b1;
    unique case (state)
      ST_COLLECT: begin
        in_ready = 1'b1;
        if (in_accept && last) begin
          load    = 1'b1;
          valid_n = 1'b1;
          state_n = ST_FULL;
        end
      end
      ST_FULL: begin
        in_ready = out_ready;
        if (out_take) begin
          valid_n = 1'b0;
          state_n = ST_COLLECT;
          clr     = ~in_accept;
        end
      end
      default: begin
        state_n = ST_COLLECT;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      state     <= state_n;
      out_valid <= valid_n;
      if (load) begin
        out_word <= next_word;
      end
    end
  end

  generate
    if (WIDTH == 8) begin : g_gates8
      logic and_lo, and_hi;
      OR_8  u_or8   (.a(out_word[7:0]), .y(out_any));
      AND_4 u_and_lo(.a(out_word[3:0]), .y(and_lo));
      AND_4 u_and_hi(.a(out_word[7:4]), .y(and_hi));
      assign out_all = and_lo & and_hi;
    end else begin : g_reduce
      assign out_any = |out_word;
      assign out_all = &out_word;
    end
  endgenerate

endmodule

// File: tb/tb_serial_collector.sv
module tb_serial_collector;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // WIDTH=8, LSB first
  logic       a_in_valid, a_in_ready, a_in_bit, a_out_valid, a_out_ready, a_out_any, a_out_all;
  logic [7:0] a_out_word;
  // WIDTH=8, MSB first
  logic       m_in_valid, m_in_ready, m_in_bit, m_out_valid, m_out_ready, m_out_any, m_out_all;
  logic [7:0] m_out_word;
  // WIDTH=4, LSB first
  logic       q_in_valid, q_in_ready, q_in_bit, q_out_valid, q_out_ready, q_out_any, q_out_all;
  logic [3:0] q_out_word;

  serial_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_word(a_out_word),
    .out_any(a_out_any), .out_all(a_out_all));

  serial_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_bit(m_in_bit),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_word(m_out_word),
    .out_any(m_out_any), .out_all(m_out_all));

  serial_collector #(.WIDTH(4), .MSB_FIRST(1'b0)) u_q (
    .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready), .in_bit(q_in_bit),
    .out_valid(q_out_valid), .out_ready(q_out_ready), .out_word(q_out_word),
    .out_any(q_out_any), .out_all(q_out_all));

  int total = 0;
  int bad   = 0;
  int m_takes = 0;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  always @(posedge clk) begin
    if (m_out_valid && m_out_ready) m_takes++;
    if (q_out_valid && q_out_ready) got_q.push_back(q_out_word);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic b);
    a_in_valid = 1'b1;
    a_in_bit   = b;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic m_send_gap(input logic b);
    int unsigned idle;
    idle = $urandom_range(0, 3);
    for (int unsigned k = 0; k < idle; k++) begin
      m_in_valid = 1'b0;
      m_in_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    m_in_valid = 1'b1;
    m_in_bit   = b;
    tick();
    m_in_valid = 1'b0;
  endtask

  task automatic q_send(input logic b);
    logic acc;
    acc = 1'b0;
    q_in_valid = 1'b1;
    q_in_bit   = b;
    for (int n = 0; n < 200 && !acc; n++) begin
      q_out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = q_in_ready;
      tick();
    end
    q_in_valid = 1'b0;
    if (!acc) chk("w4_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] s1;
    logic [7:0] s5;
    logic [3:0] nib;
    int unsigned ncnt;
    logic b;

    rst_n = 1'b0;
    a_in_valid = 0; a_in_bit = 0; a_out_ready = 1;
    m_in_valid = 0; m_in_bit = 0; m_out_ready = 1;
    q_in_valid = 0; q_in_bit = 0; q_out_ready = 0;
    #12;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_word", a_out_word, 8'h00);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_any", a_out_any, 0);
    chk("rst_all", a_out_all, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: stream 1,0,1,1,0,0,1,0 -> 8'h4D
    s1 = 8'b0100_1101;
    for (int i = 0; i < 7; i++) a_send(s1[i]);
    chk("t1_valid_before", a_out_valid, 0);
    a_send(s1[7]);
    chk("t1_valid", a_out_valid, 1);
    chk("t1_word", a_out_word, 8'h4D);
    chk("t1_any", a_out_any, 1);
    chk("t1_all", a_out_all, 0);
    tick();
    chk("t1_taken", a_out_valid, 0);
    chk("t1_word_kept", a_out_word, 8'h4D);

    // 2: consumer stalls with a bit pending
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) a_send(s1[i]);
    chk("t2_valid", a_out_valid, 1);
    a_in_valid = 1'b1;
    a_in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_ready", a_in_ready, 0);
      chk("t2_stall_word", a_out_word, 8'h4D);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("t2_ready_open", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    chk("t2_taken", a_out_valid, 0);
    for (int i = 0; i < 7; i++) a_send(1'b0);
    chk("t2_next_valid", a_out_valid, 1);
    chk("t2_next_word", a_out_word, 8'h01);
    tick();

    // 3: 8'hFF then a 0 accepted in the take cycle
    for (int i = 0; i < 7; i++) a_send(1'b1);
    a_in_valid = 1'b1;
    a_in_bit   = 1'b1;
    tick();
    chk("t3_valid", a_out_valid, 1);
    chk("t3_word", a_out_word, 8'hFF);
    chk("t3_all", a_out_all, 1);
    a_in_bit = 1'b0;
    chk("t3_ready", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    chk("t3_taken", a_out_valid, 0);
    for (int i = 0; i < 6; i++) a_send(1'b1);
    chk("t3_count1", a_out_valid, 0);
    a_send(1'b1);
    chk("t3_next_valid", a_out_valid, 1);
    chk("t3_next_word", a_out_word, 8'hFE);
    chk("t3_next_all", a_out_all, 0);
    tick();

    // 4: reset after 3 accepted bits
    a_send(1'b1); a_send(1'b1); a_send(1'b1);
    rst_n = 1'b0;
    #2;
    chk("t4_rst_word", a_out_word, 8'h00);
    chk("t4_rst_valid", a_out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) a_send(1'b0);
    chk("t4_count_cleared", a_out_valid, 0);
    a_send(1'b0);
    chk("t4_valid", a_out_valid, 1);
    chk("t4_word", a_out_word, 8'h00);
    chk("t4_any", a_out_any, 0);
    tick();

    // 5: MSB first with gaps -> 8'h81
    m_takes = 0;
    s5 = 8'b1000_0001;
    for (int i = 7; i >= 0; i--) m_send_gap(s5[i]);
    chk("t5_valid", m_out_valid, 1);
    chk("t5_word", m_out_word, 8'h81);
    tick(); tick(); tick();
    chk("t5_one_word", 32'(m_takes), 1);
    chk("t5_valid_after", m_out_valid, 0);

    // 6: WIDTH=4, 64 random bits, random out_ready
    got_q.delete();
    exp_q.delete();
    nib  = '0;
    ncnt = 0;
    for (int i = 0; i < 64; i++) begin
      b = 1'($urandom_range(0, 1));
      nib[ncnt] = b;
      ncnt++;
      if (ncnt == 4) begin
        exp_q.push_back(nib);
        ncnt = 0;
      end
      q_send(b);
    end
    q_out_ready = 1'b1;
    for (int n = 0; n < 20 && got_q.size() < 16; n++) tick();
    chk("t6_count", 32'(got_q.size()), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t6_word", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    tick(); tick(); tick();
    chk("t6_no_dup", 32'(got_q.size()), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
